// File: rtl/fetch_if_id.sv
// Instruction-fetch front end: pulls 64-byte lines over an AXI4 read-only
// master, buffers them, and issues one 32-bit instruction per cycle into the
// IF/ID pipeline register. Sequential fetch only; an all-zero word halts.
module fetch_if_id #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic                  m_axi_rlast,
  input  logic                  id_stall,
  output logic [63:0]           if_instr,
  output logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [63:0]           id_instruction,
  output logic                  id_valid,
  output logic                  halted
);

  typedef enum logic [1:0] {
    SEND_ADDR = 2'd0,
    READ_DATA = 2'd1,
    ISSUE     = 2'd2,
    HALT      = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]            beat_q, beat_d;
  logic                  halted_q, halted_d;
  logic [31:0]           line_q [16];
  logic [ADDR_WIDTH-1:0] id_pc_q;
  logic [63:0]           id_instruction_q;
  logic                  id_valid_q;

  logic [31:0] cur_instr;
  logic        beat_fire;
  logic        arvalid_c, rready_c, if_valid_c;

  // Beat counting follows the handshake alone; rlast carries no extra meaning.
  logic unused_rlast;
  assign unused_rlast = m_axi_rlast;

  assign cur_instr = line_q[pc_q[5:2]];
  assign beat_fire = (state_q == READ_DATA) && m_axi_rvalid;

  // Next-state, next-PC and handshake outputs for the fetch FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    beat_d     = beat_q;
    halted_d   = halted_q;
    arvalid_c  = 1'b0;
    rready_c   = 1'b0;
    if_valid_c = 1'b0;
    unique case (state_q)
      SEND_ADDR: begin
        // Gated by reset so the request first shows in the cycle reset rises.
        arvalid_c = reset;
        if (m_axi_arready) begin
          state_d = READ_DATA;
          beat_d  = 3'd0;
        end
      end
      READ_DATA: begin
        rready_c = 1'b1;
        if (m_axi_rvalid) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cur_instr == 32'd0) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          if_valid_c = 1'b1;
          if (!id_stall) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
            if (pc_q[5:2] == 4'hf) state_d = SEND_ADDR;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = SEND_ADDR;
    endcase
  end

  // Fetch FSM state, PC, beat counter and halt flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEND_ADDR;
      pc_q     <= entry;
      beat_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      pc_q     <= pc_d;
      beat_q   <= beat_d;
      halted_q <= halted_d;
    end
  end

  // Line buffer fill: beat k lands in slots 2k (low word) and 2k+1 (high word).
  // NOTE: the buffer has no reset; its contents are only read after a full line is written.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      line_q[{beat_q, 1'b0}] <= m_axi_rdata[31:0];
      line_q[{beat_q, 1'b1}] <= m_axi_rdata[DATA_WIDTH-1:32];
    end
  end

  // IF/ID register: loads every unstalled cycle, so an idle fetch yields a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid_q       <= 1'b0;
      id_pc_q          <= '0;
      id_instruction_q <= '0;
    end else if (!id_stall) begin
      id_valid_q       <= if_valid_c;
      id_pc_q          <= if_address;
      id_instruction_q <= if_instr;
    end
  end

  assign m_axi_araddr   = {pc_q[ADDR_WIDTH-1:6], 6'b0};
  assign m_axi_arvalid  = arvalid_c;
  assign m_axi_arlen    = 8'd7;
  assign m_axi_arsize   = 3'b011;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_rready   = rready_c;
  assign if_valid       = if_valid_c;
  assign if_address     = pc_q;
  assign if_instr       = if_valid_c ? {32'b0, cur_instr} : 64'd0;
  assign id_pc          = id_pc_q;
  assign id_instruction = id_instruction_q;
  assign id_valid       = id_valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: a procedural AXI read slave serves lines
// whose words are {tag, slot+1}; IF/ID contents are checked cycle by cycle.
module tb_fetch_if_id;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic [63:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        m_axi_rlast;
  logic        id_stall;
  logic [63:0] if_instr;
  logic [63:0] if_address;
  logic        if_valid;
  logic [63:0] id_pc;
  logic [63:0] id_instruction;
  logic        id_valid;
  logic        halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] tag      = 16'h0;
  int          zero_slot = -1;

  fetch_if_id dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .m_axi_rlast    (m_axi_rlast),
    .id_stall       (id_stall),
    .if_instr       (if_instr),
    .if_address     (if_address),
    .if_valid       (if_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .id_valid       (id_valid),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int slot);
    if (slot == zero_slot) return 32'd0;
    return {tag, 16'(slot + 1)};
  endfunction

  task automatic expect_id(input int slot, input logic [63:0] pc);
    check("id_valid", {63'd0, id_valid}, 64'd1);
    check("id_pc", id_pc, pc);
    check("id_instruction", id_instruction, {32'd0, word(slot)});
  endtask

  task automatic do_reset(input logic [63:0] entry_v);
    reset         = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = 64'd0;
    id_stall      = 1'b0;
    entry         = entry_v;
    tick();
    tick();
    check("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    check("rst_rready", {63'd0, m_axi_rready}, 64'd0);
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_id_valid", {63'd0, id_valid}, 64'd0);
    check("rst_id_pc", id_pc, 64'd0);
    check("rst_id_instr", id_instruction, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    reset = 1'b1;
    #1;
  endtask

  task automatic serve_ar(input logic [63:0] exp_addr, input int ar_delay);
    int n = 0;
    while (!m_axi_arvalid && n < 50) begin
      tick();
      n++;
    end
    check("arvalid_seen", {63'd0, m_axi_arvalid}, 64'd1);
    check("araddr", m_axi_araddr, exp_addr);
    check("arlen", {56'd0, m_axi_arlen}, 64'd7);
    check("arsize", {61'd0, m_axi_arsize}, 64'd3);
    check("arburst", {62'd0, m_axi_arburst}, 64'd1);
    repeat (ar_delay) begin
      tick();
      check("arvalid_hold", {63'd0, m_axi_arvalid}, 64'd1);
      check("araddr_hold", m_axi_araddr, exp_addr);
    end
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    check("arvalid_drop", {63'd0, m_axi_arvalid}, 64'd0);
  endtask

  task automatic serve_r(input int gap);
    for (int k = 0; k < 8; k++) begin
      repeat (gap) begin
        check("rready_gap", {63'd0, m_axi_rready}, 64'd1);
        check("if_valid_fill", {63'd0, if_valid}, 64'd0);
        tick();
      end
      check("rready", {63'd0, m_axi_rready}, 64'd1);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = {word(2 * k + 1), word(2 * k)};
      m_axi_rlast  = (k == 7);
      tick();
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
    end
  endtask

  initial begin
    int seen;

    // 1: aligned line, full walk, next line request.
    tag = 16'h0;
    do_reset(64'h1000);
    serve_ar(64'h1000, 0);
    serve_r(0);
    check("issue_if_valid", {63'd0, if_valid}, 64'd1);
    check("issue_if_addr", if_address, 64'h1000);
    check("issue_if_instr", if_instr, 64'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_id(i, 64'h1000 + 64'(4 * i));
    end
    serve_ar(64'h1040, 0);
    check("bubble_after_line", {63'd0, id_valid}, 64'd0);

    // 2: unaligned entry starts mid-line, 10 instructions.
    tag = 16'h2;
    do_reset(64'h2018);
    serve_ar(64'h2000, 0);
    serve_r(0);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_id(6 + i, 64'h2018 + 64'(4 * i));
    end
    serve_ar(64'h2040, 0);

    // 3: three-cycle stall mid-line.
    tag = 16'h3;
    do_reset(64'h3000);
    serve_ar(64'h3000, 0);
    serve_r(0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_id(i, 64'h3000 + 64'(4 * i));
    end
    id_stall = 1'b1;
    repeat (3) begin
      tick();
      expect_id(3, 64'h300C);
      check("stall_pc_hold", if_address, 64'h3010);
    end
    id_stall = 1'b0;
    for (int i = 4; i < 16; i++) begin
      tick();
      expect_id(i, 64'h3000 + 64'(4 * i));
    end

    // 4: slow arready, gapped beats, stall held across the AXI traffic.
    tag = 16'h4;
    do_reset(64'h4000);
    id_stall = 1'b1;
    serve_ar(64'h4000, 5);
    serve_r(2);
    check("stall_id_valid_held", {63'd0, id_valid}, 64'd0);
    check("fill_done_if_valid", {63'd0, if_valid}, 64'd1);
    id_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_id(i, 64'h4000 + 64'(4 * i));
    end

    // 7: top-of-memory line wraps the PC to zero.
    tag = 16'h7;
    do_reset(64'hFFFF_FFFF_FFFF_FFF8);
    serve_ar(64'hFFFF_FFFF_FFFF_FFC0, 0);
    serve_r(0);
    tick();
    expect_id(14, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    expect_id(15, 64'hFFFF_FFFF_FFFF_FFFC);
    serve_ar(64'h0, 0);

    // 5: zero word in slot 3 halts fetch.
    tag = 16'h5;
    zero_slot = 3;
    do_reset(64'h5000);
    serve_ar(64'h5000, 0);
    serve_r(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_id(i, 64'h5000 + 64'(4 * i));
    end
    check("zero_if_valid", {63'd0, if_valid}, 64'd0);
    check("halted_not_yet", {63'd0, halted}, 64'd0);
    tick();
    check("halted_set", {63'd0, halted}, 64'd1);
    check("halt_id_valid", {63'd0, id_valid}, 64'd0);
    seen = 0;
    repeat (20) begin
      tick();
      if (m_axi_arvalid || m_axi_rready || if_valid || id_valid || !halted) seen++;
    end
    check("halt_quiet", 64'(seen), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("halt_async_clear", {63'd0, halted}, 64'd0);
    zero_slot = -1;

    // 6: reset asserted mid-beat 4 of a burst.
    tag = 16'h6;
    do_reset(64'h6000);
    serve_ar(64'h6000, 0);
    for (int k = 0; k < 4; k++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = {word(2 * k + 1), word(2 * k)};
      tick();
    end
    m_axi_rdata = {word(9), word(8)};
    check("beat4_rready", {63'd0, m_axi_rready}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rready", {63'd0, m_axi_rready}, 64'd0);
    check("async_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
    check("async_id_valid", {63'd0, id_valid}, 64'd0);
    m_axi_rvalid = 1'b0;
    entry = 64'h6048;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rerun_arvalid", {63'd0, m_axi_arvalid}, 64'd1);
    check("rerun_araddr", m_axi_araddr, 64'h6040);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
